// File: rtl/tone_seq_pkg.sv
// tone_seq_pkg: shared types and constants for the tone burst sequencer.
package tone_seq_pkg;
    typedef enum logic [1:0] {IDLE, ON, OFF} state_t;
    localparam int RAMP_LEN = 16;
    localparam int GAIN_W = 5;
    localparam int SAMPLE_W = 16;
endpackage

// File: rtl/tone_seq_ramp.sv
// tone_seq_ramp: attack/release gain min(16, cnt+1, on-cnt) applied to the generator sample.
module tone_seq_ramp
    import tone_seq_pkg::*;
#(
    parameter int COUNT_W = 16
) (
    input  logic signed [SAMPLE_W-1:0] genSample_i,
    input  logic        [COUNT_W-1:0]  sampleCnt_i,
    input  logic        [COUNT_W-1:0]  onSamples_i,
    output logic signed [SAMPLE_W-1:0] sample_o
);
    localparam int PROD_W = SAMPLE_W + GAIN_W - 1;
    logic [COUNT_W:0] rise, fall, g_wide;
    logic [GAIN_W-1:0] gain;
    logic signed [PROD_W-1:0] prod;
    always_comb begin
        rise = (COUNT_W+1)'(sampleCnt_i) + (COUNT_W+1)'(1);
        fall = (COUNT_W+1)'(onSamples_i) - (COUNT_W+1)'(sampleCnt_i);
        g_wide = (rise < fall) ? rise : fall;
        gain = (g_wide > (COUNT_W+1)'(RAMP_LEN)) ? GAIN_W'(RAMP_LEN) : g_wide[GAIN_W-1:0];
        // Gain is at most 16, so the product always fits in PROD_W signed bits
        prod = PROD_W'(genSample_i) * PROD_W'($signed({1'b0, gain}));
        sample_o = SAMPLE_W'(prod >>> 4);
    end
endmodule

// File: rtl/tone_burst_sequencer.sv
// tone_burst_sequencer: N-on / M-off tone bursts, K times or continuous, driving a table tone generator.
// Define TONE_SEQ_FADE_EN to add a 16-sample linear attack/release ramp on each burst.
module tone_burst_sequencer
    import tone_seq_pkg::*;
#(
    parameter int COUNT_W = 16,
    parameter int BURST_W = 8
) (
    input  logic                       audioClock,
    input  logic                       reset,
    input  logic                       sampleEnable_i,
    input  logic                       start_i,
    input  logic                       stop_i,
    input  logic        [COUNT_W-1:0]  onSamples_i,
    input  logic        [COUNT_W-1:0]  offSamples_i,
    input  logic        [BURST_W-1:0]  burstCount_i,
    input  logic signed [SAMPLE_W-1:0] genSample_i,
    output logic                       genReset_o,
    output logic                       genEnable_o,
    output logic signed [SAMPLE_W-1:0] sample_o,
    output logic                       busy_o,
    output logic                       done_o
);
    state_t state_q, state_d;
    logic [COUNT_W-1:0] onLen_q, onLen_d, offLen_q, offLen_d, cnt_q, cnt_d;
    logic [BURST_W-1:0] bursts_q, bursts_d, burstsDone_q, burstsDone_d;
    logic pulse_q, pulse_d, done_q, done_d;
    logic signed [SAMPLE_W-1:0] sample_q, sample_d, scaled;
    logic adv, lastOn, lastOff, finalBurst;

`ifdef TONE_SEQ_FADE_EN
    tone_seq_ramp #(.COUNT_W(COUNT_W)) u_ramp (
        .genSample_i(genSample_i),
        .sampleCnt_i(cnt_q),
        .onSamples_i(onLen_q),
        .sample_o   (scaled)
    );
`else
    assign scaled = genSample_i;
`endif

    always_ff @(posedge audioClock) begin
        if (reset) begin
            state_q      <= IDLE;
            onLen_q      <= '0;
            offLen_q     <= '0;
            cnt_q        <= '0;
            bursts_q     <= '0;
            burstsDone_q <= '0;
            pulse_q      <= 1'b0;
            done_q       <= 1'b0;
            sample_q     <= '0;
        end else begin
            state_q      <= state_d;
            onLen_q      <= onLen_d;
            offLen_q     <= offLen_d;
            cnt_q        <= cnt_d;
            bursts_q     <= bursts_d;
            burstsDone_q <= burstsDone_d;
            pulse_q      <= pulse_d;
            done_q       <= done_d;
            sample_q     <= sample_d;
        end
    end

    // An enable landing on the phase-restart pulse is swallowed by the generator, so it is not counted
    assign adv = sampleEnable_i & ~pulse_q;
    assign lastOn = cnt_q == onLen_q - COUNT_W'(1);
    assign lastOff = cnt_q == offLen_q - COUNT_W'(1);
    assign finalBurst = (bursts_q != '0) && (burstsDone_q + BURST_W'(1) == bursts_q);

    always_comb begin
        state_d = state_q;
        onLen_d = onLen_q;
        offLen_d = offLen_q;
        cnt_d = cnt_q;
        bursts_d = bursts_q;
        burstsDone_d = burstsDone_q;
        pulse_d = 1'b0;
        done_d = 1'b0;
        if (stop_i) begin
            state_d = IDLE;
            cnt_d = '0;
            done_d = state_q != IDLE;
        end else begin
            case (state_q)
                IDLE: if (start_i) begin
                    if (onSamples_i != '0) begin
                        onLen_d = onSamples_i;
                        offLen_d = offSamples_i;
                        bursts_d = burstCount_i;
                        cnt_d = '0;
                        burstsDone_d = '0;
                        pulse_d = 1'b1;
                        state_d = ON;
                    end else begin
                        done_d = 1'b1;
                    end
                end
                ON: if (adv) begin
                    if (lastOn) begin
                        cnt_d = '0;
                        burstsDone_d = burstsDone_q + BURST_W'(1);
                        if (finalBurst) begin
                            state_d = IDLE;
                            done_d = 1'b1;
                        end else if (offLen_q == '0) begin
                            pulse_d = 1'b1;
                        end else begin
                            state_d = OFF;
                        end
                    end else begin
                        cnt_d = cnt_q + COUNT_W'(1);
                    end
                end
                OFF: if (adv) begin
                    if (lastOff) begin
                        cnt_d = '0;
                        pulse_d = 1'b1;
                        state_d = ON;
                    end else begin
                        cnt_d = cnt_q + COUNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        sample_d = stop_i ? '0 : sampleEnable_i ? ((state_q == ON) ? scaled : '0) : sample_q;
    end

    always_comb begin
        genReset_o = reset | pulse_q;
        genEnable_o = sampleEnable_i & (state_q == ON) & ~genReset_o;
        busy_o = state_q != IDLE;
        done_o = done_q;
        sample_o = sample_q;
    end
endmodule
